// File: rtl/pipelined_rca.sv
// ---------------------------------------------------------------------------
// pipelined_rca
//
// Pipelined ripple-carry adder/subtractor built from full-adder cells.  The
// WIDTH-bit operation is cut into STAGES = WIDTH/SEG segments.  Each segment
// is a SEG-bit ripple chain followed by a register.  A valid bit travels with
// the data, and the pipeline honours the processor's stall and flush controls.
//
// Parameters
//   WIDTH      operand / result width in bits (default 32)
//   SEG        bits per pipeline segment (default 8); WIDTH % SEG must be 0
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   valid_in   operands present this cycle
//   a, b       operands (WIDTH bits)
//   sub        1: a - b (b inverted, carry-in forced to 1); 0: a + b + cin
//   cin        carry-in for add; ignored for subtract
//   stall      freeze the entire pipeline
//   flush      kill every in-flight operation, including the incoming one
//   valid_out  result valid
//   sum        result (modulo 2^WIDTH)
//   cout       carry out of the MSB; for subtract 1 means no borrow
//   ovf        signed overflow  (only with PIPELINED_RCA_FLAGS_EN, else 0)
//   zero       sum == 0         (only with PIPELINED_RCA_FLAGS_EN, else 0)
//
// Optional feature macro: PIPELINED_RCA_FLAGS_EN
//   When defined, the final stage also registers the ovf and zero flags,
//   aligned with sum.  When undefined, both outputs are tied low and no flag
//   logic exists.
//
// Latency is exactly STAGES cycles: an operation accepted at edge N appears
// on the outputs after edge N+STAGES-1.  Throughput is one operation per
// unstalled cycle.
// ---------------------------------------------------------------------------
module pipelined_rca #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    input  logic             stall,
    input  logic             flush,
    output logic             valid_out,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / SEG;

    // A partial last segment would silently drop or misalign bits, so refuse
    // to elaborate rather than build a wrong adder.
    if ((SEG < 1) || (WIDTH % SEG != 0)) begin : g_bad_seg
        $error("pipelined_rca: WIDTH (%0d) must be a non-zero multiple of SEG (%0d)",
               WIDTH, SEG);
    end

    // Subtract is a + ~b + 1, so inversion and carry-in forcing happen once,
    // before the first segment; later segments only ever see the effective B.
    logic [WIDTH-1:0] b_eff;
    logic             carry_in0;

    assign b_eff     = sub ? ~b : b;
    assign carry_in0 = sub | cin;

    // One full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic s;
        logic co;
        s  = x ^ y ^ ci;
        co = (x & y) | (x & ci) | (y & ci);
        return {co, s};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Number of operand bits that still have to be added by later stages.
        localparam int REM = WIDTH - (k + 1) * SEG;

        logic [SEG-1:0]         seg_a;
        logic [SEG-1:0]         seg_b;
        logic                   seg_cin;
        logic                   in_valid;
        logic [SEG-1:0]         seg_sum;
        logic                   seg_cout;
        logic [(k+1)*SEG-1:0]   sum_next;

        logic [(k+1)*SEG-1:0]   sum_q;
        logic                   carry_q;
        logic                   valid_q;

        // Operand segment, carry and valid come from the ports for the first
        // stage and from the previous stage's registers for every later one.
        // The skew registers are kept shifted so the next segment to add is
        // always in their low SEG bits.  The finished lower sum bits travel in
        // sum_q (the deskew path) and grow by one segment per stage.
        if (k == 0) begin : g_in
            assign seg_a    = a[SEG-1:0];
            assign seg_b    = b_eff[SEG-1:0];
            assign seg_cin  = carry_in0;
            assign in_valid = valid_in;
            assign sum_next = seg_sum;
        end else begin : g_in
            assign seg_a    = g_stage[k-1].g_skew.a_q[SEG-1:0];
            assign seg_b    = g_stage[k-1].g_skew.b_q[SEG-1:0];
            assign seg_cin  = g_stage[k-1].carry_q;
            assign in_valid = g_stage[k-1].valid_q;
            assign sum_next = {seg_sum, g_stage[k-1].sum_q};
        end

        // The segment's ripple chain: SEG full-adder cells in series.
        always_comb begin
            logic c;
            c       = seg_cin;
            seg_sum = '0;
            for (int i = 0; i < SEG; i++) begin
                {c, seg_sum[i]} = full_add(seg_a[i], seg_b[i], c);
            end
            seg_cout = c;
        end

        // Stage register.  Stall freezes everything; flush only has to kill the
        // valid bit because data in an invalid slot is never looked at.  Flush
        // is applied last so it wins over stall and over a new valid_in.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                if (!stall) begin
                    sum_q   <= sum_next;
                    carry_q <= seg_cout;
                    valid_q <= in_valid;
                end
                if (flush) begin
                    valid_q <= 1'b0;
                end
            end
        end

        // Skew registers carrying the not-yet-added operand bits forward.
        // The last stage has nothing left to forward, so it has none.
        if (k < STAGES - 1) begin : g_skew
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;
            logic [REM-1:0] a_next;
            logic [REM-1:0] b_next;

            if (k == 0) begin : g_src
                assign a_next = a[WIDTH-1:SEG];
                assign b_next = b_eff[WIDTH-1:SEG];
            end else begin : g_src
                assign a_next = g_stage[k-1].g_skew.a_q[REM+SEG-1:SEG];
                assign b_next = g_stage[k-1].g_skew.b_q[REM+SEG-1:SEG];
            end

            // Skew registers follow the same hold/clear rules as the stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_next;
                    b_q <= b_next;
                end
            end
        end

`ifdef PIPELINED_RCA_FLAGS_EN
        // Flags live in the final stage so they line up with sum without any
        // extra latency.  In the top segment, bit SEG-1 is the operand MSB.
        if (k == STAGES - 1) begin : g_flags
            logic ovf_q;
            logic zero_q;
            logic ovf_next;

            assign ovf_next = (seg_a[SEG-1] == seg_b[SEG-1]) &
                              (seg_sum[SEG-1] != seg_a[SEG-1]);

            // Flag registers hold under stall just like the sum they describe.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q  <= ovf_next;
                    zero_q <= ~|sum_next;
                end
            end
        end
`endif
    end

    assign valid_out = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;

`ifdef PIPELINED_RCA_FLAGS_EN
    assign ovf  = g_stage[STAGES-1].g_flags.ovf_q;
    assign zero = g_stage[STAGES-1].g_flags.zero_q;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// ---------------------------------------------------------------------------
// tb_pipelined_rca
//
// Self-checking bench for pipelined_rca.  Three instances share one stimulus
// stream: SEG=8 (4 stages), SEG=4 (8 stages) and SEG=32 (1 stage).
//
// Reference model: every accepted operation is logged with its result,
// computed by plain integer arithmetic, and tagged with the value of an
// "advance" counter that ticks on every unstalled edge.  An instance with S
// stages must present an operation exactly when the counter has moved S-1
// past that operation's tag.  Flush and reset empty the log.
// ---------------------------------------------------------------------------
module tb_pipelined_rca;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             valid_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             stall;
    logic             flush;

    logic             v8, v4, v32;
    logic [WIDTH-1:0] s8, s4, s32;
    logic             c8, c4, c32;
    logic             o8, o4, o32;
    logic             z8, z4, z32;

    pipelined_rca #(.WIDTH(WIDTH), .SEG(8)) dut8 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .a(a), .b(b), .sub(sub),
        .cin(cin), .stall(stall), .flush(flush), .valid_out(v8), .sum(s8),
        .cout(c8), .ovf(o8), .zero(z8)
    );

    pipelined_rca #(.WIDTH(WIDTH), .SEG(4)) dut4 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .a(a), .b(b), .sub(sub),
        .cin(cin), .stall(stall), .flush(flush), .valid_out(v4), .sum(s4),
        .cout(c4), .ovf(o4), .zero(z4)
    );

    pipelined_rca #(.WIDTH(WIDTH), .SEG(32)) dut32 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .a(a), .b(b), .sub(sub),
        .cin(cin), .stall(stall), .flush(flush), .valid_out(v32), .sum(s32),
        .cout(c32), .ovf(o32), .zero(z32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
        logic             z;
        int               tag;
    } op_t;

    op_t log_q[$];
    int  adv;
    int  compared;
    int  mismatched;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference result of the operation currently on the inputs.
    function automatic op_t refResult();
        op_t              r;
        logic [WIDTH-1:0] be;
        logic             ci;
        logic [WIDTH:0]   full;
        longint           sv;
        be   = sub ? ~b : b;
        ci   = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, ci};
        sv   = longint'($signed(a)) + longint'($signed(be)) + longint'(ci);
        r.s  = full[WIDTH-1:0];
        r.c  = full[WIDTH];
`ifdef PIPELINED_RCA_FLAGS_EN
        r.o  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        r.z  = (full[WIDTH-1:0] == '0);
`else
        r.o  = 1'b0;
        r.z  = 1'b0;
`endif
        r.tag = 0;
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs the DUTs sampled.
    task automatic modelEdge();
        op_t r;
        if (rst || flush) begin
            log_q.delete();
        end else if (!stall) begin
            adv++;
            if (valid_in) begin
                r     = refResult();
                r.tag = adv;
                log_q.push_back(r);
            end
            while (log_q.size() > 0 && (adv - log_q[0].tag) > 8) begin
                void'(log_q.pop_front());
            end
        end
    endtask

    task automatic checkInstance(input string name, input int stages, input logic v,
                                 input logic [WIDTH-1:0] s, input logic c,
                                 input logic o, input logic z, input logic was_reset);
        bit  found;
        op_t e;
        found = 1'b0;
        e     = '{default: '0};
        foreach (log_q[i]) begin
            if ((adv - log_q[i].tag) == stages - 1) begin
                found = 1'b1;
                e     = log_q[i];
            end
        end
        checkOutput({name, ".valid_out"}, 64'(v), 64'(found));
        if (was_reset) begin
            checkOutput({name, ".rst_sum"},  64'(s), 64'd0);
            checkOutput({name, ".rst_cout"}, 64'(c), 64'd0);
            checkOutput({name, ".rst_ovf"},  64'(o), 64'd0);
            checkOutput({name, ".rst_zero"}, 64'(z), 64'd0);
        end else if (found) begin
            checkOutput({name, ".sum"},  64'(s), 64'(e.s));
            checkOutput({name, ".cout"}, 64'(c), 64'(e.c));
            checkOutput({name, ".ovf"},  64'(o), 64'(e.o));
            checkOutput({name, ".zero"}, 64'(z), 64'(e.z));
        end
    endtask

    // One clock cycle: drive inputs, let the edge happen, update the model,
    // then check every instance 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] aa,
                                 input logic [WIDTH-1:0] bb, input logic sb,
                                 input logic ci, input logic st, input logic fl,
                                 input logic r);
        valid_in = v;
        a        = aa;
        b        = bb;
        sub      = sb;
        cin      = ci;
        stall    = st;
        flush    = fl;
        rst      = r;
        @(posedge clk);
        modelEdge();
        #1;
        checkInstance("seg8",  4, v8,  s8,  c8,  o8,  z8,  r);
        checkInstance("seg4",  8, v4,  s4,  c4,  o4,  z4,  r);
        checkInstance("seg32", 1, v32, s32, c32, o32, z32, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        adv        = 0;
        valid_in   = 1'b0;
        a          = '0;
        b          = '0;
        sub        = 1'b0;
        cin        = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        rst        = 1'b1;
        #2;

        $display("[TB] reset");
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] reset with a full pipeline");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'(i + 1) * 32'h1111_1111, 32'h0101_0101, 1'b0, 1'b0,
                          1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(10);

        $display("[TB] carry through every segment");
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        checkOutput("t2.valid", 64'(v8), 64'd1);
        checkOutput("t2.sum",   64'(s8), 64'h0);
        checkOutput("t2.cout",  64'(c8), 64'd1);
`ifdef PIPELINED_RCA_FLAGS_EN
        checkOutput("t2.zero",  64'(z8), 64'd1);
`endif
        idle(1);
        checkOutput("t2.single", 64'(v8), 64'd0);
        idle(4);

        $display("[TB] overflow then borrow");
        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        checkOutput("t3a.sum",  64'(s8), 64'h8000_0000);
        checkOutput("t3a.cout", 64'(c8), 64'd0);
`ifdef PIPELINED_RCA_FLAGS_EN
        checkOutput("t3a.ovf",  64'(o8), 64'd1);
`endif
        idle(1);
        checkOutput("t3b.sum",  64'(s8), 64'hFFFF_FFFE);
        checkOutput("t3b.cout", 64'(c8), 64'd0);
        checkOutput("t3b.ovf",  64'(o8), 64'd0);
        idle(8);

        $display("[TB] stream with a mid-stream stall");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'(i) * 32'h0123_4567, 32'h00FF_00FF + 32'(i), 1'b0,
                          1'(i), 1'b0, 1'b0, 1'b0);
            if (i == 2) begin
                for (int j = 0; j < 3; j++) begin
                    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'hBAD0_BAD0, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b0);
                end
            end
        end
        idle(10);

        $display("[TB] flush with ops in flight");
        applyStimulus(1'b1, 32'h1000_0000, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2000_0000, 32'h0000_0022, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h3000_0000, 32'h0000_0033, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h4000_0000, 32'h0000_0044, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(10);

        $display("[TB] random operands");
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 32'($urandom), 32'($urandom),
                          1'($urandom), 1'($urandom),
                          1'($urandom_range(0, 9) == 0),
                          1'($urandom_range(0, 39) == 0),
                          1'($urandom_range(0, 199) == 0));
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
